// File: rtl/rob_commit_pkg.sv
// Shared constants for the reorder buffer: tag width, entry count and entry type codes.
package rob_commit_pkg;

  localparam int unsigned ROB_BIT  = 3;
  localparam int unsigned ROB_SIZE = 1 << ROB_BIT;

  localparam logic [1:0] ROB_REG    = 2'd0;
  localparam logic [1:0] ROB_BRANCH = 2'd1;
  localparam logic [1:0] ROB_STORE  = 2'd2;
  localparam logic [1:0] ROB_NOP    = 2'd3;

  // STORE and NOP have nothing to wait for, so they are complete as soon as they issue.
  function automatic logic ready_at_issue(input logic [1:0] etype);
    return (etype == ROB_STORE) || (etype == ROB_NOP);
  endfunction

endpackage

// File: rtl/rob_commit_query.sv
// Operand query port of the ROB: returns the finished value of one tag.
// With ROB_BYPASS_EN defined, same-cycle RS/LSB broadcasts are forwarded (RS first).
module rob_commit_query
  import rob_commit_pkg::*;
(
  input  logic [ROB_BIT-1:0] query_entry,
  input  logic               entry_ready,
  input  logic [31:0]        entry_value,
  input  logic               rs_ready,
  input  logic [ROB_BIT-1:0] rs_rob_entry,
  input  logic [31:0]        rs_value,
  input  logic               lsb_ready,
  input  logic [ROB_BIT-1:0] lsb_rob_entry,
  input  logic [31:0]        lsb_value,
  output logic               query_ready,
  output logic [31:0]        query_value
);

  // Registered entry state, optionally overridden by a matching broadcast.
  always_comb begin
    query_ready = entry_ready;
    query_value = entry_value;
`ifdef ROB_BYPASS_EN
    if (rs_ready && (rs_rob_entry == query_entry)) begin
      query_ready = 1'b1;
      query_value = rs_value;
    end else if (lsb_ready && (lsb_rob_entry == query_entry)) begin
      query_ready = 1'b1;
      query_value = lsb_value;
    end
`endif
  end

`ifndef ROB_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{query_entry, rs_ready, rs_rob_entry, rs_value,
                           lsb_ready, lsb_rob_entry, lsb_value};
`endif

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: allocates circular entries at issue, captures RS/LSB broadcasts by tag,
// retires in order one per cycle and raises a global flush on branch mispredict.
// Optional: ROB_BYPASS_EN forwards same-cycle broadcasts to the query ports.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               issue_signal,
  input  logic [1:0]         issue_type,
  input  logic [4:0]         issue_rd,
  input  logic               issue_pred_taken,
  input  logic [31:0]        issue_alt_pc,
  output logic [ROB_BIT-1:0] rob_tail,
  output logic [ROB_BIT-1:0] rob_head,
  output logic               rob_full,
  input  logic               rs_ready,
  input  logic [ROB_BIT-1:0] rs_rob_entry,
  input  logic [31:0]        rs_value,
  input  logic               lsb_ready,
  input  logic [ROB_BIT-1:0] lsb_rob_entry,
  input  logic [31:0]        lsb_value,
  input  logic [ROB_BIT-1:0] query_entry1,
  input  logic [ROB_BIT-1:0] query_entry2,
  output logic               query_ready1,
  output logic               query_ready2,
  output logic [31:0]        query_value1,
  output logic [31:0]        query_value2,
  output logic               commit_valid,
  output logic [4:0]         commit_rd,
  output logic [31:0]        commit_value,
  output logic [ROB_BIT-1:0] commit_rob_entry,
  output logic               store_commit,
  output logic               rob_clear_up,
  output logic [31:0]        clear_pc
);

  logic [ROB_SIZE-1:0] busy_q, busy_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  logic [ROB_SIZE-1:0] pred_q, pred_d;
  logic [1:0]          etype_q [ROB_SIZE];
  logic [1:0]          etype_d [ROB_SIZE];
  logic [4:0]          rd_q    [ROB_SIZE];
  logic [4:0]          rd_d    [ROB_SIZE];
  logic [31:0]         value_q [ROB_SIZE];
  logic [31:0]         value_d [ROB_SIZE];
  logic [31:0]         alt_q   [ROB_SIZE];
  logic [31:0]         alt_d   [ROB_SIZE];

  logic [ROB_BIT-1:0]  head_q, head_d, tail_q, tail_d;
  logic [ROB_BIT:0]    count_q, count_d;

  logic                commit_valid_q, commit_valid_d;
  logic [4:0]          commit_rd_q, commit_rd_d;
  logic [31:0]         commit_value_q, commit_value_d;
  logic [ROB_BIT-1:0]  commit_entry_q, commit_entry_d;
  logic                store_commit_q, store_commit_d;
  logic                clear_up_q, clear_up_d;
  logic [31:0]         clear_pc_q, clear_pc_d;

  logic                retire, issue_fire;

  // Full is taken from the registered count, so a retire frees its slot one cycle later.
  assign rob_full   = (count_q == (ROB_BIT + 1)'(ROB_SIZE));
  assign retire     = busy_q[head_q] && ready_q[head_q] && !clear_up_q;
  assign issue_fire = issue_signal && !rob_full && !clear_up_q;

  // Next-state: flush, writeback, in-order retire and tail allocation.
  always_comb begin
    busy_d         = busy_q;
    ready_d        = ready_q;
    pred_d         = pred_q;
    etype_d        = etype_q;
    rd_d           = rd_q;
    value_d        = value_q;
    alt_d          = alt_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_entry_d = commit_entry_q;
    store_commit_d = 1'b0;
    clear_up_d     = 1'b0;
    clear_pc_d     = '0;

    if (clear_up_q) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // LSB first so that an RS broadcast to the same tag overrides it.
      if (lsb_ready && busy_q[lsb_rob_entry] && !ready_q[lsb_rob_entry]) begin
        ready_d[lsb_rob_entry] = 1'b1;
        value_d[lsb_rob_entry] = lsb_value;
      end
      if (rs_ready && busy_q[rs_rob_entry] && !ready_q[rs_rob_entry]) begin
        ready_d[rs_rob_entry] = 1'b1;
        value_d[rs_rob_entry] = rs_value;
      end

      if (retire) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + ROB_BIT'(1);
        case (etype_q[head_q])
          ROB_REG: begin
            commit_valid_d = 1'b1;
            commit_rd_d    = rd_q[head_q];
            commit_value_d = value_q[head_q];
            commit_entry_d = head_q;
          end
          ROB_STORE: begin
            store_commit_d = 1'b1;
            commit_entry_d = head_q;
          end
          ROB_BRANCH: begin
            if (value_q[head_q][0] != pred_q[head_q]) begin
              clear_up_d = 1'b1;
              clear_pc_d = alt_q[head_q];
            end
          end
          default: ;
        endcase
      end

      if (issue_fire) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = ready_at_issue(issue_type);
        etype_d[tail_q] = issue_type;
        rd_d[tail_q]    = issue_rd;
        pred_d[tail_q]  = issue_pred_taken;
        alt_d[tail_q]   = issue_alt_pc;
        value_d[tail_q] = '0;
        tail_d          = tail_q + ROB_BIT'(1);
      end

      count_d = count_q + (ROB_BIT + 1)'(issue_fire) - (ROB_BIT + 1)'(retire);
    end
  end

  // State registers; everything freezes while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q         <= '0;
      ready_q        <= '0;
      pred_q         <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        etype_q[i] <= '0;
        rd_q[i]    <= '0;
        value_q[i] <= '0;
        alt_q[i]   <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_entry_q <= '0;
      store_commit_q <= 1'b0;
      clear_up_q     <= 1'b0;
      clear_pc_q     <= '0;
    end else if (rdy_in) begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      pred_q         <= pred_d;
      etype_q        <= etype_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      alt_q          <= alt_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_entry_q <= commit_entry_d;
      store_commit_q <= store_commit_d;
      clear_up_q     <= clear_up_d;
      clear_pc_q     <= clear_pc_d;
    end
  end

  assign rob_tail         = tail_q;
  assign rob_head         = head_q;
  assign commit_valid     = commit_valid_q;
  assign commit_rd        = commit_rd_q;
  assign commit_value     = commit_value_q;
  assign commit_rob_entry = commit_entry_q;
  assign store_commit     = store_commit_q;
  assign rob_clear_up     = clear_up_q;
  assign clear_pc         = clear_pc_q;

  rob_commit_query u_query1 (
    .query_entry   (query_entry1),
    .entry_ready   (busy_q[query_entry1] && ready_q[query_entry1]),
    .entry_value   (value_q[query_entry1]),
    .rs_ready      (rs_ready),
    .rs_rob_entry  (rs_rob_entry),
    .rs_value      (rs_value),
    .lsb_ready     (lsb_ready),
    .lsb_rob_entry (lsb_rob_entry),
    .lsb_value     (lsb_value),
    .query_ready   (query_ready1),
    .query_value   (query_value1)
  );

  rob_commit_query u_query2 (
    .query_entry   (query_entry2),
    .entry_ready   (busy_q[query_entry2] && ready_q[query_entry2]),
    .entry_value   (value_q[query_entry2]),
    .rs_ready      (rs_ready),
    .rs_rob_entry  (rs_rob_entry),
    .rs_value      (rs_value),
    .lsb_ready     (lsb_ready),
    .lsb_rob_entry (lsb_rob_entry),
    .lsb_value     (lsb_value),
    .query_ready   (query_ready2),
    .query_value   (query_value2)
  );

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: queue-based reference model plus directed scenarios.
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy_in;
  logic        issue_signal;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic        issue_pred_taken;
  logic [31:0] issue_alt_pc;
  logic [2:0]  rob_tail, rob_head;
  logic        rob_full;
  logic        rs_ready, lsb_ready;
  logic [2:0]  rs_rob_entry, lsb_rob_entry;
  logic [31:0] rs_value, lsb_value;
  logic [2:0]  query_entry1, query_entry2;
  logic        query_ready1, query_ready2;
  logic [31:0] query_value1, query_value2;
  logic        commit_valid, store_commit, rob_clear_up;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, clear_pc;
  logic [2:0]  commit_rob_entry;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .rdy_in           (rdy_in),
    .issue_signal     (issue_signal),
    .issue_type       (issue_type),
    .issue_rd         (issue_rd),
    .issue_pred_taken (issue_pred_taken),
    .issue_alt_pc     (issue_alt_pc),
    .rob_tail         (rob_tail),
    .rob_head         (rob_head),
    .rob_full         (rob_full),
    .rs_ready         (rs_ready),
    .rs_rob_entry     (rs_rob_entry),
    .rs_value         (rs_value),
    .lsb_ready        (lsb_ready),
    .lsb_rob_entry    (lsb_rob_entry),
    .lsb_value        (lsb_value),
    .query_entry1     (query_entry1),
    .query_entry2     (query_entry2),
    .query_ready1     (query_ready1),
    .query_ready2     (query_ready2),
    .query_value1     (query_value1),
    .query_value2     (query_value2),
    .commit_valid     (commit_valid),
    .commit_rd        (commit_rd),
    .commit_value     (commit_value),
    .commit_rob_entry (commit_rob_entry),
    .store_commit     (store_commit),
    .rob_clear_up     (rob_clear_up),
    .clear_pc         (clear_pc)
  );

`ifdef ROB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: in-flight instructions, oldest first ----------------
  typedef struct {
    logic [1:0]  ty;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] alt;
    logic        done;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  int          m_head;
  bit          m_flush;
  bit          e_cv, e_sc, e_clr;
  logic [4:0]  e_rd;
  logic [31:0] e_val, e_cpc;
  logic [2:0]  e_entry;

  function automatic int m_off(input logic [2:0] tag);
    return (int'(tag) - m_head) & 7;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_head = 0; m_flush = 0;
    e_cv = 0; e_sc = 0; e_clr = 0;
    e_rd = '0; e_val = '0; e_cpc = '0; e_entry = '0;
  endtask

  task automatic m_wb(input logic [2:0] tag, input logic [31:0] v);
    int   off;
    ent_t e;
    off = m_off(tag);
    if (off < mq.size()) begin
      e = mq[off];
      if (!e.done) begin
        e.done = 1'b1;
        e.val  = v;
        mq[off] = e;
      end
    end
  endtask

  task automatic m_step();
    ent_t e;
    bit   r;
    int   pre_size;
    if (m_flush) begin
      mq.delete();
      m_head = 0; m_flush = 0;
      e_cv = 0; e_sc = 0; e_clr = 0;
      return;
    end
    pre_size = mq.size();
    r = (pre_size > 0) && mq[0].done;
    e_cv = 0; e_sc = 0; e_clr = 0;
    if (r) begin
      e = mq[0];
      case (e.ty)
        ROB_REG:   begin e_cv = 1; e_rd = e.rd; e_val = e.val; e_entry = 3'(m_head); end
        ROB_STORE: begin e_sc = 1; e_entry = 3'(m_head); end
        ROB_BRANCH: if (e.val[0] != e.pred) begin e_clr = 1; e_cpc = e.alt; m_flush = 1; end
        default: ;
      endcase
    end
    if (lsb_ready && !(rs_ready && rs_rob_entry == lsb_rob_entry)) m_wb(lsb_rob_entry, lsb_value);
    if (rs_ready) m_wb(rs_rob_entry, rs_value);
    if (r) begin
      void'(mq.pop_front());
      m_head = (m_head + 1) & 7;
    end
    if (issue_signal && pre_size < 8) begin
      e.ty   = issue_type;
      e.rd   = issue_rd;
      e.pred = issue_pred_taken;
      e.alt  = issue_alt_pc;
      e.done = (issue_type == ROB_STORE) || (issue_type == ROB_NOP);
      e.val  = '0;
      mq.push_back(e);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else if (rdy_in) m_step();
  end

  task automatic q_exp(input logic [2:0] tag, output logic rdy, output logic [31:0] val);
    int off;
    off = m_off(tag);
    rdy = (off < mq.size()) && mq[off].done;
    val = rdy ? mq[off].val : 32'h0;
    if (Bypass && rs_ready && rs_rob_entry == tag) begin
      rdy = 1'b1; val = rs_value;
    end else if (Bypass && lsb_ready && lsb_rob_entry == tag) begin
      rdy = 1'b1; val = lsb_value;
    end
  endtask

  // Compare DUT against the model in the middle of every cycle.
  always @(negedge clk) begin
    logic        qr;
    logic [31:0] qv;
    chk("rob_tail", 32'(rob_tail), 32'((m_head + mq.size()) & 7));
    chk("rob_head", 32'(rob_head), 32'(m_head));
    chk("rob_full", 32'(rob_full), 32'(mq.size() == 8));
    chk("commit_valid", 32'(commit_valid), 32'(e_cv));
    if (e_cv) begin
      chk("commit_rd", 32'(commit_rd), 32'(e_rd));
      chk("commit_value", commit_value, e_val);
      chk("commit_rob_entry", 32'(commit_rob_entry), 32'(e_entry));
    end
    chk("store_commit", 32'(store_commit), 32'(e_sc));
    if (e_sc) chk("store_entry", 32'(commit_rob_entry), 32'(e_entry));
    chk("rob_clear_up", 32'(rob_clear_up), 32'(e_clr));
    if (e_clr) chk("clear_pc", clear_pc, e_cpc);
    q_exp(query_entry1, qr, qv);
    chk("query_ready1", 32'(query_ready1), 32'(qr));
    if (qr) chk("query_value1", query_value1, qv);
    q_exp(query_entry2, qr, qv);
    chk("query_ready2", 32'(query_ready2), 32'(qr));
    if (qr) chk("query_value2", query_value2, qv);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; issue_signal = 1'b0; issue_type = ROB_REG; issue_rd = '0;
    issue_pred_taken = 1'b0; issue_alt_pc = '0;
    rs_ready = 1'b0; rs_rob_entry = '0; rs_value = '0;
    lsb_ready = 1'b0; lsb_rob_entry = '0; lsb_value = '0;
    query_entry1 = '0; query_entry2 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input logic [1:0] ty, input logic [4:0] rd, input logic pred,
                       input logic [31:0] alt);
    issue_signal = 1'b1; issue_type = ty; issue_rd = rd;
    issue_pred_taken = pred; issue_alt_pc = alt;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    chk("reset_full", 32'(rob_full), 0);
    chk("reset_tail", 32'(rob_tail), 0);
    chk("reset_commit_valid", 32'(commit_valid), 0);
    do_reset();

    // Single REG issue, broadcast, retire.
    issue(ROB_REG, 5'd5, 1'b0, 32'h0);
    cyc();
    idle(); rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'h1234;
    cyc();
    idle();
    cyc();
    chk("t1_valid", 32'(commit_valid), 1);
    chk("t1_rd", 32'(commit_rd), 5);
    chk("t1_value", commit_value, 32'h1234);
    chk("t1_entry", 32'(commit_rob_entry), 0);
    cyc();
    chk("t1_pulse_one_cycle", 32'(commit_valid), 0);

    // Out-of-order completion, in-order commit.
    do_reset();
    issue(ROB_REG, 5'd1, 1'b0, 32'h0);
    cyc();
    issue(ROB_REG, 5'd2, 1'b0, 32'h0);
    cyc();
    idle(); rs_ready = 1'b1; rs_rob_entry = 3'd1; rs_value = 32'hB;
    cyc();
    idle(); rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'hA;
    cyc();
    idle();
    cyc();
    chk("t2_first_entry", 32'(commit_rob_entry), 0);
    chk("t2_first_value", commit_value, 32'hA);
    cyc();
    chk("t2_second_valid", 32'(commit_valid), 1);
    chk("t2_second_entry", 32'(commit_rob_entry), 1);
    chk("t2_second_value", commit_value, 32'hB);

    // Fill, ignored 9th issue, retire one, wrap.
    do_reset();
    issue(ROB_REG, 5'd7, 1'b0, 32'h0);
    repeat (8) cyc();
    chk("t3_full", 32'(rob_full), 1);
    chk("t3_tail_wrap", 32'(rob_tail), 0);
    cyc();
    chk("t3_ninth_ignored_tail", 32'(rob_tail), 0);
    chk("t3_still_full", 32'(rob_full), 1);
    idle(); rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'h55;
    cyc();
    idle();
    cyc();
    chk("t3_retire_valid", 32'(commit_valid), 1);
    chk("t3_not_full", 32'(rob_full), 0);
    chk("t3_head", 32'(rob_head), 1);
    issue(ROB_REG, 5'd9, 1'b0, 32'h0);
    cyc();
    idle();
    chk("t3_tail_after_wrap", 32'(rob_tail), 1);
    chk("t3_full_again", 32'(rob_full), 1);

    // Branch mispredict flush; issue during the flush cycle is dropped.
    do_reset();
    issue(ROB_BRANCH, 5'd0, 1'b1, 32'h104);
    cyc();
    issue(ROB_REG, 5'd3, 1'b0, 32'h0);
    rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'h0;
    cyc();
    idle();
    cyc();
    chk("t4_clear", 32'(rob_clear_up), 1);
    chk("t4_clear_pc", clear_pc, 32'h104);
    chk("t4_tail_before", 32'(rob_tail), 2);
    issue(ROB_REG, 5'd4, 1'b0, 32'h0);
    cyc();
    idle();
    chk("t4_clear_done", 32'(rob_clear_up), 0);
    chk("t4_tail_empty", 32'(rob_tail), 0);
    chk("t4_head_empty", 32'(rob_head), 0);

    // Query while broadcasting.
    do_reset();
    issue(ROB_REG, 5'd1, 1'b0, 32'h0);
    repeat (3) cyc();
    idle(); query_entry1 = 3'd2; rs_ready = 1'b1; rs_rob_entry = 3'd2; rs_value = 32'd7;
    #1;
    chk("t5_query_same_cycle", 32'(query_ready1), 32'(Bypass));
    cyc();
    rs_ready = 1'b0;
    #1;
    chk("t5_query_next_ready", 32'(query_ready1), 1);
    chk("t5_query_next_value", query_value1, 32'd7);

    // Asynchronous reset mid-run with 5 entries busy.
    do_reset();
    issue(ROB_REG, 5'd2, 1'b0, 32'h0);
    repeat (5) cyc();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_full", 32'(rob_full), 0);
    chk("t6_tail", 32'(rob_tail), 0);
    chk("t6_commit_valid", 32'(commit_valid), 0);
    chk("t6_store_commit", 32'(store_commit), 0);
    chk("t6_clear", 32'(rob_clear_up), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rdy_in           = ($urandom % 8) != 0;
      issue_signal     = ($urandom % 2) != 0;
      issue_type       = 2'($urandom % 4);
      issue_rd         = 5'($urandom);
      issue_pred_taken = 1'($urandom);
      issue_alt_pc     = $urandom;
      rs_ready         = ($urandom % 2) != 0;
      rs_value         = $urandom;
      if (mq.size() > 0 && ($urandom % 4) != 0)
        rs_rob_entry = 3'((m_head + int'($urandom % mq.size())) & 7);
      else
        rs_rob_entry = 3'($urandom);
      lsb_ready        = ($urandom % 3) == 0;
      lsb_value        = $urandom;
      if (mq.size() > 0 && ($urandom % 4) != 0)
        lsb_rob_entry = 3'((m_head + int'($urandom % mq.size())) & 7);
      else
        lsb_rob_entry = 3'($urandom);
      if (rs_ready && lsb_ready && rs_rob_entry == lsb_rob_entry) lsb_ready = 1'b0;
      query_entry1     = 3'($urandom);
      query_entry2     = 3'($urandom);
      cyc();
    end

    idle();
    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer: the consumer end of the result broadcast bus that the reservation station and LSB drive.
- Allocates a circular entry per issued instruction and captures RS/LSB results by ROB tag.
- Retires entries in order, one per cycle, to the register file and LSB.
- Raises the global flush (rob_clear_up) on branch mispredict.

Parameters:
ROB_BIT, 3, log2 of entry count (ROB_SIZE = 1<<ROB_BIT = 8)

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global ready; all state frozen when low
issue_signal  in  1  allocate tail entry this cycle
issue_type  in  2  0=REG (writes rd), 1=BRANCH, 2=STORE, 3=NOP
issue_rd  in  5  destination register
issue_pred_taken  in  1  predictor decision for BRANCH
issue_alt_pc  in  32  PC of the path not predicted
rob_tail  out  ROB_BIT  tag the next issue receives
rob_head  out  ROB_BIT  oldest entry tag (LSB uses it for store ordering)
rob_full  out  1  count == ROB_SIZE
rs_ready  in  1  RS/ALU broadcast valid
rs_rob_entry  in  ROB_BIT  broadcast tag
rs_value  in  32  broadcast value (BRANCH: bit0 = taken)
lsb_ready  in  1  LSB broadcast valid
lsb_rob_entry  in  ROB_BIT  broadcast tag
lsb_value  in  32  load value
query_entry1, query_entry2  in  ROB_BIT  decoder operand tags
query_ready1, query_ready2  out  1  tag holds a finished value
query_value1, query_value2  out  32  finished value
commit_valid  out  1  register-writing retire this cycle
commit_rd  out  5  retired rd
commit_value  out  32  retired value
commit_rob_entry  out  ROB_BIT  retired tag (regfile clears its dependency if it matches)
store_commit  out  1  head STORE retired; LSB may perform the memory write
rob_clear_up  out  1  flush pulse
clear_pc  out  32  redirect PC, valid with rob_clear_up

Behaviour:
- Reset (rst_in=0, async): head=tail=count=0; all entries not busy; every output 0.
- State per entry: busy, ready, type, rd, value, pred_taken, alt_pc.
- rdy_in=0: no state change; outputs hold.
- Issue (issue_signal && !rob_full && !rob_clear_up):
  - tail entry gets busy=1 and captures all issue fields.
  - ready is set at issue when type is STORE or NOP; otherwise ready=0.
  - tail advances by 1, wrapping modulo ROB_SIZE.
  - Issue while full is ignored.
- Writeback:
  - An rs_ready or lsb_ready broadcast whose tag names a busy, not-ready entry sets ready=1 and value=broadcast value at the edge.
  - A tag naming a non-busy or already-ready entry is ignored.
  - RS and LSB naming the same tag in one cycle is illegal; RS wins.
- Commit:
  - At each edge where the head entry is busy and ready, it retires: busy=0 and head advances.
  - At most one retire per edge.
  - Registered pulses, high one cycle after the retire edge:
    - REG: commit_valid, with rd/value/tag.
    - STORE: store_commit, with commit_rob_entry.
    - NOP: no pulse.
  - Latency: broadcast at edge N, ready at N, retire at edge N+1, pulse during cycle N+1.
- Branch retire:
  - Mispredict when value[0] != pred_taken.
  - On mispredict: rob_clear_up=1 and clear_pc=alt_pc, both registered for one cycle.
  - While rob_clear_up=1, the next edge empties the ROB (head=tail=count=0, all busy cleared) and ignores issue, writeback and commit.
  - A correct branch retires silently.
- Count:
  - Issue and retire on the same edge leave count unchanged.
  - Retire frees the slot for an issue on the following cycle, not the same cycle: rob_full is computed from registered count.
- Query (combinational): query_readyX = busy[tag] && ready[tag]; query_valueX = value[tag].
- Wrap: with tail=7, an issue goes to tag 7 and tail becomes 0; head wraps identically.

Optional Feature:
- ROB_BYPASS_EN defined: the query ports also forward same-cycle broadcasts. If rs_ready and rs_rob_entry==query_entryX, then ready=1 and value=rs_value. If lsb_ready matches, the lsb value is forwarded. RS has priority.
- Undefined: queries see registered entry state only; a broadcast is visible one cycle later.

Decomposition:
- Const.v gains ROB_BIT/ROB_SIZE and the ROB type codes (ROB_REG, ROB_BRANCH, ROB_STORE, ROB_NOP).
- No sub-module is needed. The query/bypass mux may be split into rob_query (pure combinational, instanced twice).

Test Plan:
- Reset mid-run with 5 entries busy -> rob_full=0, rob_tail=0, all pulse outputs 0 immediately, without waiting for a clock edge.
- Issue REG rd=5 at tag 0; rs broadcast tag 0 value 0x1234 -> one cycle later commit_valid=1, commit_rd=5, commit_value=0x1234, commit_rob_entry=0.
- Out-of-order completion: issue tags 0,1; broadcast tag 1 first, then tag 0 -> commits occur in order 0, then 1 on consecutive cycles.
- Fill 8 entries -> rob_full=1 and a 9th issue is ignored. Retire one -> tail wraps to 0 and the next issue lands at tag 0.
- BRANCH pred_taken=1, alt_pc=0x104, rs value 0 -> rob_clear_up=1 with clear_pc=0x104 for one cycle; the next cycle shows an empty ROB with rob_tail=rob_head.
- Query tag 2 while rs broadcasts tag 2 value 7 -> query_ready=1 and value 7 with ROB_BYPASS_EN; ready=0 that cycle without it, then 1 the next cycle.
